// File: rtl/popcnt_rr_sched.sv
// Round-robin shared serial ones counter for two requesters.
// Optional macro POPCNT_EARLY_EXIT_EN ends COUNT as soon as the remaining shift register bits are zero.
module popcnt_rr_sched #(
    parameter int DATA_W       = 16,
    parameter int BITS_PER_CYC = 4,
    parameter int CNT_W        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  rsp_ones,
    output logic              busy
);

    localparam int NSTEPS = DATA_W / BITS_PER_CYC;
    localparam int STEP_W = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {IDLE, COUNT, RESP} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  shreg, shreg_shifted;
    logic [CNT_W-1:0]   acc, acc_nxt;
    logic [STEP_W-1:0]  step;
    logic               id, last_grant, grant, accept, count_done;

    function automatic logic [CNT_W-1:0] slice_ones(input logic [BITS_PER_CYC-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // Grant goes to the sole valid requester; on a tie, to the one not served last.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    assign req0_ready    = (state == IDLE) && req0_valid && !grant;
    assign req1_ready    = (state == IDLE) && req1_valid && grant;
    assign accept        = req0_ready || req1_ready;
    assign acc_nxt       = acc + slice_ones(shreg[BITS_PER_CYC-1:0]);
    assign shreg_shifted = shreg >> BITS_PER_CYC;

`ifdef POPCNT_EARLY_EXIT_EN
    assign count_done = (step == STEP_W'(NSTEPS - 1)) || (shreg_shifted == '0);
`else
    assign count_done = (step == STEP_W'(NSTEPS - 1));
`endif

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = COUNT;
            COUNT:   if (count_done) state_nxt = RESP;
            RESP:    if (rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            acc        <= '0;
            step       <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    shreg      <= grant ? req1_data : req0_data;
                    acc        <= '0;
                    step       <= '0;
                    id         <= grant;
                    last_grant <= grant;
                end
                COUNT: begin
                    acc   <= acc_nxt;
                    shreg <= shreg_shifted;
                    step  <= step + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The accumulator holds its final sum throughout RESP, so it drives the result directly.
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id;
    assign rsp_ones  = acc;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_popcnt_rr_sched.sv
// Directed self-checking bench for popcnt_rr_sched; latency expectations follow POPCNT_EARLY_EXIT_EN.
module tb_popcnt_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
    logic [4:0]  rsp_ones;

    int checks = 0;
    int failures = 0;

    popcnt_rr_sched #(.DATA_W(16), .BITS_PER_CYC(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_ones(rsp_ones), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a word, wait (bounded) for the grant, pass the accept edge, then drop valid.
    task automatic send(input bit port, input logic [15:0] d);
        int n = 0;
        if (port) begin req1_valid = 1'b1; req1_data = d; end
        else      begin req0_valid = 1'b1; req0_data = d; end
        #1;
        while (!(port ? req1_ready : req0_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout: port %0d never saw ready", port);
        end
        @(posedge clk); #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Count edges until rsp_valid, noting whether busy stayed high and both readies stayed low.
    task automatic wait_rsp(output int cyc, output bit busy_ok, output bit ready_ok);
        cyc = 0; busy_ok = 1'b1; ready_ok = 1'b1;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (!busy) busy_ok = 1'b0;
            if (req0_ready || req1_ready) ready_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        checks += 6;
        if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        if (rsp_id !== 1'b0)     begin failures++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
        if (rsp_ones !== 5'd0)   begin failures++; $display("FAIL reset_rsp_ones: got %0d expected 0", rsp_ones); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready: got %b expected 0", req0_ready); end
        if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready: got %b expected 0", req1_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks += 2;
        if (req0_ready !== 1'b1) begin failures++; $display("FAIL reset_tie_req0: got %b expected 1", req0_ready); end
        if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_tie_req1: got %b expected 0", req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        int cyc; bit b_ok, r_ok;
        do_reset();
        rsp_ready = 1'b1;
        send(1'b0, 16'hFFFF);
        wait_rsp(cyc, b_ok, r_ok);
        checks += 4;
        if (cyc != 4)            begin failures++; $display("FAIL single_latency: got %0d expected 4", cyc); end
        if (rsp_ones !== 5'd16)  begin failures++; $display("FAIL single_ones: got %0d expected 16", rsp_ones); end
        if (rsp_id !== 1'b0)     begin failures++; $display("FAIL single_id: got %b expected 0", rsp_id); end
        if (!b_ok)               begin failures++; $display("FAIL single_busy: got low expected high while counting"); end
        @(posedge clk); #1;
        checks += 2;
        if (busy !== 1'b0)       begin failures++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL single_valid_after: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vec [3] = '{16'hF56F, 16'h3FFF, 16'h0001};
        logic [4:0]  exp [3] = '{5'd12, 5'd14, 5'd1};
        int cyc, n; bit b_ok, r_ok;
        do_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_data = vec[0];
        #1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!req1_ready && n < 20) begin @(posedge clk); #1; n++; end
            checks++;
            if (n >= 20) begin failures++; $display("FAIL b2b_grant%0d: got no ready expected ready", i); end
            @(posedge clk); #1;
            if (i < 2) req1_data = vec[i+1]; else req1_valid = 1'b0;
            wait_rsp(cyc, b_ok, r_ok);
            checks += 3;
            if (rsp_ones !== exp[i]) begin failures++; $display("FAIL b2b_ones%0d: got %0d expected %0d", i, rsp_ones, exp[i]); end
            if (rsp_id !== 1'b1)     begin failures++; $display("FAIL b2b_id%0d: got %b expected 1", i, rsp_id); end
            if (!r_ok)               begin failures++; $display("FAIL b2b_ready%0d: got high expected low while busy", i); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness();
        logic       exp_id   [3] = '{1'b0, 1'b1, 1'b0};
        logic [4:0] exp_ones [3] = '{5'd9, 5'd6, 5'd9};
        int cyc; bit b_ok, r_ok;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 16'hF10F;
        req1_valid = 1'b1; req1_data = 16'h7822;
        for (int i = 0; i < 3; i++) begin
            wait_rsp(cyc, b_ok, r_ok);
            checks += 2;
            if (rsp_id !== exp_id[i])     begin failures++; $display("FAIL fair_id%0d: got %b expected %b", i, rsp_id, exp_id[i]); end
            if (rsp_ones !== exp_ones[i]) begin failures++; $display("FAIL fair_ones%0d: got %0d expected %0d", i, rsp_ones, exp_ones[i]); end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc; bit b_ok, r_ok, hold_ok;
        do_reset();
        rsp_ready = 1'b0;
        send(1'b0, 16'h7ABC);
        req1_valid = 1'b1; req1_data = 16'h0F0F;
        wait_rsp(cyc, b_ok, r_ok);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_ones !== 5'd10 || rsp_id !== 1'b0 || req1_ready !== 1'b0) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks += 2;
        if (!hold_ok) begin failures++; $display("FAIL bp_hold: got unstable response or ready expected ones=10 held"); end
        if (rsp_ones !== 5'd10) begin failures++; $display("FAIL bp_ones: got %0d expected 10", rsp_ones); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL bp_release: got %b expected 0", rsp_valid); end
        if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_req1_ready: got %b expected 1", req1_ready); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(cyc, b_ok, r_ok);
        checks += 2;
        if (rsp_ones !== 5'd8) begin failures++; $display("FAIL bp_next_ones: got %0d expected 8", rsp_ones); end
        if (rsp_id !== 1'b1)   begin failures++; $display("FAIL bp_next_id: got %b expected 1", rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc; bit b_ok, r_ok, quiet;
        do_reset();
        rsp_ready = 1'b1;
        send(1'b0, 16'hFFFF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", rsp_valid); end
        if (rsp_ones !== 5'd0)  begin failures++; $display("FAIL mid_ones: got %0d expected 0", rsp_ones); end
        if (rsp_id !== 1'b0)    begin failures++; $display("FAIL mid_id: got %b expected 0", rsp_id); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        @(posedge clk); #1 rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL mid_no_rsp: got activity expected idle after reset"); end
        req0_valid = 1'b1; req0_data = 16'h00FF;
        req1_valid = 1'b1; req1_data = 16'h000F;
        wait_rsp(cyc, b_ok, r_ok);
        checks += 2;
        if (rsp_id !== 1'b0)   begin failures++; $display("FAIL mid_tie_id: got %b expected 0", rsp_id); end
        if (rsp_ones !== 5'd8) begin failures++; $display("FAIL mid_tie_ones: got %0d expected 8", rsp_ones); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [15:0] vec  [3] = '{16'h0001, 16'h0000, 16'hF000};
        logic [4:0]  ones [3] = '{5'd1, 5'd0, 5'd4};
`ifdef POPCNT_EARLY_EXIT_EN
        int lat [3] = '{1, 1, 4};
`else
        int lat [3] = '{4, 4, 4};
`endif
        int cyc; bit b_ok, r_ok;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, vec[i]);
            wait_rsp(cyc, b_ok, r_ok);
            checks += 2;
            if (cyc != lat[i])         begin failures++; $display("FAIL lat_cycles%0d: got %0d expected %0d", i, cyc, lat[i]); end
            if (rsp_ones !== ones[i])  begin failures++; $display("FAIL lat_ones%0d: got %0d expected %0d", i, rsp_ones, ones[i]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcnt_rr_sched.md
Name: popcnt_rr_sched

Overview:
- Shares one multi-cycle serial ones-count engine between two requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Response is tagged with the requester ID.
- Sits between the front-end word producers and the statistics logic. Replaces duplicated combinational 16-bit ones counters with one time-shared, area-cheap unit.

Parameters:
- DATA_W, 16: input word width. Must be an integer multiple of BITS_PER_CYC.
- BITS_PER_CYC, 4: bits examined per COUNT cycle.
- CNT_W, 5: result width. Must equal clog2(DATA_W+1), so an all-ones word is representable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  DATA_W  requester 0 word; sampled only on handshake
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has a word
- req1_data  in  DATA_W  requester 1 word
- req1_ready  out  1  requester 1 accepted this cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_ones  out  CNT_W  number of 1 bits in the accepted word
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n; all state clears immediately on assertion.
- Reset values:
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_ones=0, busy=0.
  - req0_ready=0, req1_ready=0.
  - Round-robin pointer: last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, COUNT, RESP.
- IDLE:
  - grant = the sole valid requester. If both are valid, grant = the one not equal to last_grant.
  - reqX_ready = (state==IDLE) && reqX_valid && grant==X. This is combinational and at most one ready is high.
  - On handshake: load shift register with reqX_data, clear accumulator, clear step counter, record id, set last_grant=X, go to COUNT.
  - No valid requester: stay in IDLE.
- COUNT:
  - Each cycle: acc += number of ones in shreg[BITS_PER_CYC-1:0]; shreg >>= BITS_PER_CYC; step++.
  - After step reaches DATA_W/BITS_PER_CYC: go to RESP. rsp_ones=acc (including the final add), rsp_valid=1, rsp_id=recorded id.
  - Accumulator width is CNT_W; it never overflows given the CNT_W rule.
- Latency: rsp_valid rises exactly DATA_W/BITS_PER_CYC clock edges after the acceptance edge (4 with defaults).
- RESP:
  - Hold rsp_valid, rsp_id and rsp_ones stable until rsp_ready=1.
  - On handshake edge: rsp_valid=0, go to IDLE.
  - No new acceptance in the handshake cycle. Peak throughput is one word per DATA_W/BITS_PER_CYC + 2 cycles.
  - rsp_ready while rsp_valid=0 is ignored.
- Backpressure: requests arriving during COUNT or RESP see ready=0. The requester must hold valid and data until accepted.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Reset mid-operation: the in-flight word is discarded and no response is issued. Ordering restarts with requester 0.
- Zero word: completes with rsp_ones=0 and normal latency.

Optional Feature:
- Macro: POPCNT_EARLY_EXIT_EN.
- Defined: in COUNT, if the shift register after the current shift is zero, go to RESP on that edge, even if step < DATA_W/BITS_PER_CYC. Latency becomes 1..DATA_W/BITS_PER_CYC, set by the highest set nibble; a zero word takes 1 cycle.
- Not defined: fixed latency as above; no zero-detect logic is synthesized.
- rsp_ones is identical in both builds.

Test Plan:
- Single request, default build: req0 data=16'hFFFF, rsp_ready=1 → rsp_valid 4 edges after accept; rsp_ones=16, rsp_id=0; busy high throughout, low after the handshake.
- Back-to-back on req1: 16'hF56F, 16'h3FFF, 16'h0001 → responses 12, 14, 1 in order, all with rsp_id=1; ready low during COUNT/RESP.
- Both requesters valid continuously after reset: req0=16'hF10F, req1=16'h7822 → first response id0/9, then id1/6, then id0/9; grants strictly alternate.
- Backpressure: req0=16'h7ABC, rsp_ready=0 for 10 cycles → rsp_valid/rsp_ones=10 held stable; req1_ready stays 0; accepted only after rsp_ready=1.
- Reset mid-COUNT: assert rsp_ready=1, accept 16'hFFFF, drop rst_n 2 cycles later → all outputs 0 immediately; no response after release; next tie grants req0.
- POPCNT_EARLY_EXIT_EN defined: 16'h0001 → rsp_ones=1 after 1 edge; 16'h0000 → 0 after 1 edge; 16'hF000 → 4 after 4 edges.
